// File: rtl/single_fetch_if.sv
// ============================================================================
//  single_fetch_if
//  Core / instruction-memory signal bundle for the single-cycle fetch unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

interface single_fetch_if #(
  parameter int N = 32,
  parameter int W = 32
);
  logic [N-1:0] pc_in;
  logic         flush;
  logic         mem_req;
  logic [N-1:0] mem_addr;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;
  logic [W-1:0] inst;
  logic         inst_valid;
  logic         stall;
  logic         fetch_err;

  // The fetch unit takes the slave view; core and memory models take master.
  modport slave (
    input  pc_in, flush, mem_ack, mem_rdata,
    output mem_req, mem_addr, inst, inst_valid, stall, fetch_err
  );

  modport master (
    output pc_in, flush, mem_ack, mem_rdata,
    input  mem_req, mem_addr, inst, inst_valid, stall, fetch_err
  );
endinterface

`default_nettype wire

// File: rtl/single_fetch.sv
// ============================================================================
//  single_fetch
//  Instruction fetch with a one-entry buffer, req/ack memory handshake,
//  miss stall and sticky timeout error.
//  Rev 1.0
// ============================================================================
`default_nettype none

module single_fetch #(
  parameter int N       = 32,
  parameter int W       = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  single_fetch_if.slave bus
);

  localparam logic [1:0]   S_IDLE    = 2'd0;
  localparam logic [1:0]   S_REQ     = 2'd1;
  localparam logic [1:0]   S_ERR     = 2'd2;
  localparam logic [N-1:0] ALL_ONES  = '1;
  localparam logic [7:0]   TCNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]   state_q,     state_d;
  logic         mem_req_q,   mem_req_d;
  logic [N-1:0] mem_addr_q,  mem_addr_d;
  logic [N-1:0] req_addr_q,  req_addr_d;
  logic [N-1:0] buf_addr_q,  buf_addr_d;
  logic [W-1:0] buf_data_q,  buf_data_d;
  logic         buf_valid_q, buf_valid_d;
  logic [7:0]   tcnt_q,      tcnt_d;
  logic         discard_q,   discard_d;
  logic         fetch_err_q, fetch_err_d;

  logic pc_live;
  logic hit;

  assign pc_live = (bus.pc_in != ALL_ONES);
  assign hit     = buf_valid_q && (buf_addr_q == bus.pc_in) && pc_live;

  assign bus.inst_valid = hit && (state_q != S_ERR);
  assign bus.inst       = bus.inst_valid ? buf_data_q : '0;
  assign bus.stall      = (state_q == S_ERR) || (!hit && pc_live);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fetch_err  = fetch_err_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    req_addr_d  = req_addr_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_valid_d = buf_valid_q;
    tcnt_d      = tcnt_q;
    discard_d   = discard_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          buf_valid_d = 1'b0;
        end else if (!hit && pc_live) begin
          req_addr_d = bus.pc_in;
          mem_addr_d = bus.pc_in;
          mem_req_d  = 1'b1;
          tcnt_d     = 8'd0;
          discard_d  = 1'b0;
          state_d    = S_REQ;
        end
      end

      S_REQ: begin
        // A flushed fetch still completes its handshake; only the data is dropped.
        if (bus.flush) begin
          discard_d   = 1'b1;
          buf_valid_d = 1'b0;
        end
        if (bus.mem_ack) begin
          if (!(discard_q || bus.flush)) begin
            buf_data_d  = bus.mem_rdata;
            buf_addr_d  = req_addr_q;
            buf_valid_d = 1'b1;
          end
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else if (tcnt_q == TCNT_LAST) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          buf_valid_d = 1'b0;
          state_d     = S_ERR;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      default: begin
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= ALL_ONES;
      req_addr_q  <= ALL_ONES;
      buf_addr_q  <= ALL_ONES;
      buf_data_q  <= '0;
      buf_valid_q <= 1'b0;
      tcnt_q      <= 8'd0;
      discard_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      req_addr_q  <= req_addr_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      buf_valid_q <= buf_valid_d;
      tcnt_q      <= tcnt_d;
      discard_q   <= discard_d;
      fetch_err_q <= fetch_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_single_fetch.sv
// ============================================================================
//  tb_single_fetch
//  Directed self-checking bench for single_fetch (TIMEOUT = 4).
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_single_fetch;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  single_fetch_if #(.N(32), .W(32)) bus ();

  single_fetch #(.N(32), .W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks sit 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    bus.pc_in      = 32'hFFFF_FFFF;
    bus.flush      = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;

    step();
    step();
    #1;
    check("rst_mem_req",    32'(bus.mem_req),    32'd0);
    check("rst_mem_addr",   bus.mem_addr,        32'hFFFF_FFFF);
    check("rst_stall",      32'(bus.stall),      32'd0);
    check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst",       bus.inst,            32'd0);
    check("rst_fetch_err",  32'(bus.fetch_err),  32'd0);
    rst = 1'b0;

    // Miss at PC 0, ack in the third request cycle.
    step();
    bus.pc_in = 32'h0000_0000;
    #1;
    check("miss0_stall_c0", 32'(bus.stall),   32'd1);
    check("miss0_req_c0",   32'(bus.mem_req), 32'd0);
    step();
    #1;
    check("miss0_req_c1",   32'(bus.mem_req), 32'd1);
    check("miss0_addr_c1",  bus.mem_addr,     32'h0000_0000);
    check("miss0_stall_c1", 32'(bus.stall),   32'd1);
    step();
    #1;
    check("miss0_stall_c2", 32'(bus.stall),   32'd1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2008_0005;
    #1;
    check("miss0_stall_c3", 32'(bus.stall),   32'd1);
    step();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    check("miss0_inst",       bus.inst,            32'h2008_0005);
    check("miss0_inst_valid", 32'(bus.inst_valid), 32'd1);
    check("miss0_req_done",   32'(bus.mem_req),    32'd0);
    check("miss0_stall_done", 32'(bus.stall),      32'd0);

    // Hits on the buffered PC generate no traffic.
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check("hit_no_req", 32'(bus.mem_req),    32'd0);
      check("hit_valid",  32'(bus.inst_valid), 32'd1);
    end

    // Minimum-penalty miss at PC 4.
    bus.pc_in = 32'h0000_0004;
    #1;
    check("miss4_stall", 32'(bus.stall), 32'd1);
    step();
    #1;
    check("miss4_req",  32'(bus.mem_req), 32'd1);
    check("miss4_addr", bus.mem_addr,     32'h0000_0004);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("miss4_inst",  bus.inst,            32'h0000_0013);
    check("miss4_valid", 32'(bus.inst_valid), 32'd1);
    check("miss4_req0",  32'(bus.mem_req),    32'd0);

    // Flush during an outstanding request to 0x8 drops the returned data.
    bus.pc_in = 32'h0000_0008;
    step();
    #1;
    check("fl_req",  32'(bus.mem_req), 32'd1);
    check("fl_addr", bus.mem_addr,     32'h0000_0008);
    bus.flush = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("fl_req_held", 32'(bus.mem_req), 32'd1);
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("fl_req_drop",  32'(bus.mem_req),    32'd0);
    check("fl_not_valid", 32'(bus.inst_valid), 32'd0);
    check("fl_inst_zero", bus.inst,            32'd0);
    check("fl_stall",     32'(bus.stall),      32'd1);
    step();
    #1;
    check("fl_rereq",      32'(bus.mem_req), 32'd1);
    check("fl_rereq_addr", bus.mem_addr,     32'h0000_0008);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8C22_0000;
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("fl_fill_inst",  bus.inst,            32'h8C22_0000);
    check("fl_fill_valid", 32'(bus.inst_valid), 32'd1);

    // PC moves from 0x10 to 0x14 while the 0x10 request is outstanding.
    bus.pc_in = 32'h0000_0010;
    step();
    #1;
    check("pcmv_addr10", bus.mem_addr, 32'h0000_0010);
    bus.pc_in = 32'h0000_0014;
    step();
    #1;
    check("pcmv_addr_held", bus.mem_addr, 32'h0000_0010);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hAAAA_0010;
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("pcmv_req0",   32'(bus.mem_req),    32'd0);
    check("pcmv_miss14", 32'(bus.inst_valid), 32'd0);
    check("pcmv_stall",  32'(bus.stall),      32'd1);
    step();
    #1;
    check("pcmv_req14",  32'(bus.mem_req), 32'd1);
    check("pcmv_addr14", bus.mem_addr,     32'h0000_0014);
    bus.pc_in = 32'h0000_0010;
    #1;
    check("pcmv_buf10_valid", 32'(bus.inst_valid), 32'd1);
    check("pcmv_buf10_inst",  bus.inst,            32'hAAAA_0010);
    bus.pc_in     = 32'h0000_0014;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBBBB_0014;
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("pcmv_fill14", bus.inst,            32'hBBBB_0014);
    check("pcmv_valid",  32'(bus.inst_valid), 32'd1);

    // Memory never answers a request to 0x20.
    bus.pc_in = 32'h0000_0020;
    step();
    #1;
    check("to_req", 32'(bus.mem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("to_no_err_yet", 32'(bus.fetch_err), 32'd0);
      check("to_req_held",   32'(bus.mem_req),   32'd1);
    end
    step();
    #1;
    check("to_err",   32'(bus.fetch_err), 32'd1);
    check("to_req0",  32'(bus.mem_req),   32'd0);
    check("to_stall", 32'(bus.stall),     32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    bus.pc_in     = 32'h0000_0014;
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("err_ack_ignored_stall", 32'(bus.stall),      32'd1);
    check("err_ack_ignored_valid", 32'(bus.inst_valid), 32'd0);
    check("err_req_low",           32'(bus.mem_req),    32'd0);
    check("err_sticky",            32'(bus.fetch_err),  32'd1);
    rst = 1'b1;
    #1;
    check("err_rst_clear", 32'(bus.fetch_err), 32'd0);
    check("err_rst_buf",   32'(bus.inst_valid), 32'd0);
    bus.pc_in = 32'hFFFF_FFFF;
    #1;
    check("err_rst_stall", 32'(bus.stall), 32'd0);
    step();
    rst = 1'b0;

    // Asynchronous reset mid-request, then a late ack in IDLE.
    bus.pc_in = 32'h0000_0030;
    step();
    #1;
    check("ar_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req_async_drop", 32'(bus.mem_req), 32'd0);
    step();
    rst           = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    step();
    bus.mem_ack = 1'b0;
    #1;
    check("ar_late_ack_valid", 32'(bus.inst_valid), 32'd0);
    check("ar_rereq",          32'(bus.mem_req),    32'd1);
    check("ar_rereq_addr",     bus.mem_addr,        32'h0000_0030);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/single_fetch.md
# single_fetch

Instruction fetch unit for the single-cycle CPU. It takes the current program counter from the PC register and fetches the instruction at that address from an instruction memory over a req/ack handshake. A one-entry instruction buffer serves repeated fetches of the same address. The block stalls the core while a miss is outstanding, and raises a sticky error if memory never answers.

## Interface
- N, 32: address / PC width.
- W, 32: instruction width.
- TIMEOUT, 16: consecutive un-acked request cycles before error; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  N  current PC; all-ones is the reset PC and means "no fetch".
- flush  in  1  invalidate buffer / discard in-flight fetch.
- mem_req  out  1  request to instruction memory, registered.
- mem_addr  out  N  request address, registered, stable while mem_req=1.
- mem_ack  in  1  memory response strobe, one cycle, valid only while mem_req=1.
- mem_rdata  in  W  instruction data, valid when mem_ack=1.
- inst  out  W  instruction for pc_in.
- inst_valid  out  1  inst corresponds to pc_in this cycle.
- stall  out  1  core must hold its PC.
- fetch_err  out  1  sticky memory timeout flag.

## Operation
- Storage:
  - buf_addr [N], buf_data [W], buf_valid.
  - state ∈ {IDLE, REQ, ERR}.
  - req_addr [N].
  - 8-bit timeout counter tcnt.
  - discard flag.
- hit = buf_valid && buf_addr == pc_in && pc_in != all-ones. This is combinational.
- Outputs (combinational from state/buffer):
  - inst_valid = hit && state != ERR.
  - inst = buf_data when inst_valid, else 0.
  - stall = (state == ERR) || (!hit && pc_in != all-ones).
- IDLE:
  - If flush: clear buf_valid, stay IDLE.
  - Else if !hit and pc_in != all-ones: req_addr <= pc_in, mem_addr <= pc_in, mem_req <= 1, tcnt <= 0, discard <= 0, go REQ.
  - Else stay IDLE.
- REQ:
  - mem_req and mem_addr are held.
  - flush sets discard and clears buf_valid; the handshake is never abandoned.
  - On mem_ack=1:
    - If discard (including flush in the same cycle), data is dropped.
    - Otherwise buf_data <= mem_rdata, buf_addr <= req_addr, buf_valid <= 1.
    - Then mem_req <= 0, go IDLE.
  - On mem_ack=0:
    - If tcnt == TIMEOUT-1: mem_req <= 0, fetch_err <= 1, buf_valid <= 0, go ERR.
    - Else tcnt <= tcnt+1.
- ERR: terminal until rst. mem_req=0, stall=1, inst_valid=0; mem_ack is ignored.
- pc_in changing during REQ does not alter mem_addr. The completed fill carries the old address, and IDLE then misses and refetches.
- mem_ack outside REQ is ignored.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_addr=all-ones, buf_valid=0, buf_addr=all-ones, buf_data=0, tcnt=0, discard=0, fetch_err=0.
- With pc_in all-ones at reset, the derived outputs are inst=0, inst_valid=0, stall=0.
- Miss with pc_in stable before edge k:
  - stall=1 combinationally from that cycle.
  - mem_req=1 after edge k.
  - Ack sampled at edge k+L (L≥1) fills the buffer.
  - mem_req=0, inst_valid=1, stall=0 after edge k+L.
- Minimum miss penalty is 2 edges (ack in the first req cycle).
- Hit: zero latency, no memory traffic.
- Timeout: TIMEOUT consecutive REQ edges with ack=0 lead to ERR after the TIMEOUT-th edge.
- rst asserted mid-REQ: mem_req drops immediately (async) and the buffer is lost. A late ack after reset release is ignored, because it is not in REQ.
- Back-to-back misses: one idle cycle with mem_req=0 between requests, since IDLE re-evaluates after each fill.

## Test plan
- Reset, pc_in=FFFFFFFF: mem_req=0, stall=0, inst_valid=0, inst=0, fetch_err=0.
- pc_in=00000000, memory acks after 3 cycles with 0x20080005: mem_addr=0, stall high 4 cycles; then inst=0x20080005, inst_valid=1, mem_req=0.
- Same PC held 5 more cycles: no further mem_req, inst_valid stays 1. Then pc_in=00000004: new request with mem_addr=4.
- Flush asserted during an outstanding request to 0x8, ack with 0xDEADBEEF: data not stored, returns to IDLE. Re-request to 0x8 issues one cycle later, then fills normally.
- TIMEOUT=4, memory never acks: fetch_err=1 after the 4th REQ edge, mem_req=0, stall stays 1 through a later ack; rst clears everything.
- pc_in changes from 0x10 to 0x14 mid-request: mem_addr stays 0x10. After the fill, the buffer holds 0x10, the block misses, and fetches 0x14 next.
